rv32_dmem_bridge: RTL and testbench

Data-side memory bridge that sits directly downstream of the CPU core's data port. It turns the core's single-cycle, synchronous-memory style request (enable/read/addr/store) into a request/grant/response bus transaction that may take many cycles. While a transaction is outstanding, it holds the core with `stall`. It returns load data on a registered `data_fetch` that stays stable until the next request is accepted, and bounds every transaction with a timeout.

---
 rtl/rv32_mem_pkg.sv | 14 +
 rtl/dmem_timeout_ctr.sv | 36 +++
 rtl/rv32_dmem_bridge.sv | 151 +++++++++++++++
 tb/tb_rv32_dmem_bridge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the data-side memory bridge.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          DMEM_CNT_W    = 8;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Cycle counter bounding a bus transaction; flags the cycle in which the
// TIMEOUT-th busy cycle is being spent.
module dmem_timeout_ctr
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [DMEM_CNT_W:0] LP_LIMIT = (DMEM_CNT_W + 1)'(TIMEOUT);

    logic [DMEM_CNT_W-1:0] r_cnt;
    logic [DMEM_CNT_W:0]   w_next;

    // r_cnt holds the number of busy cycles already completed, so the
    // current cycle is number r_cnt+1; expiry fires when that reaches TIMEOUT.
    assign w_next  = {1'b0, r_cnt} + {{DMEM_CNT_W{1'b0}}, 1'b1};
    assign expired = enable && (w_next == LP_LIMIT);

    // Clear on entry to a new transaction, count busy cycles, never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != '1)) begin
            r_cnt <= w_next[DMEM_CNT_W-1:0];
        end
    end

endmodule

// File: rtl/rv32_dmem_bridge.sv
// Bridges the core's single-cycle data port onto a request/grant/response
// bus, stalling the core while a transaction is outstanding.
module rv32_dmem_bridge
    import rv32_mem_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DMEM_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_enable,
    input  logic        data_read,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_store,
    output logic [31:0] data_fetch,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic [7:0]  err_count
);

    dmem_state_t r_state;
    logic        r_read;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_data_fetch;
    logic        r_bus_err;
    logic [7:0]  r_err_count;

    logic w_accept;
    logic w_busy;
    logic w_expired;
    logic w_done_req;
    logic w_done_wait;
    logic w_complete;
    logic w_timeout;

    assign w_accept = (r_state == IDLE) && data_enable;
    assign w_busy   = (r_state == REQ) || (r_state == WAIT);

    // A store completes on grant; a load completes on grant only when the
    // response arrives in the same cycle, otherwise later in WAIT.
    assign w_done_req  = (r_state == REQ) && mem_gnt && (!r_read || mem_rvalid);
    assign w_done_wait = (r_state == WAIT) && mem_rvalid;
    assign w_complete  = w_done_req || w_done_wait;

    // Completion beats expiry in the same cycle. A load grant alone does not
    // count as completion, so the transaction stays bounded.
    assign w_timeout = w_expired && !w_complete;

    dmem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_accept),
        .enable  (w_busy),
        .expired (w_expired)
    );

    // Request FSM with registered bus outputs, load data and error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_read       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_data_fetch <= '0;
            r_bus_err    <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (data_enable) begin
                        r_read    <= data_read;
                        r_addr    <= data_addr & 32'hFFFF_FFFC;
                        r_wdata   <= data_store;
                        r_mem_we  <= ~data_read;
                        r_mem_req <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (w_done_req) begin
                        r_mem_req <= 1'b0;
                        if (r_read) begin
                            r_data_fetch <= mem_rdata;
                        end
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        if (r_read) begin
                            r_data_fetch <= ERR_DATA;
                        end
                        r_bus_err <= 1'b1;
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                        r_state <= DONE;
                    end else if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_done_wait) begin
                        r_data_fetch <= mem_rdata;
                        r_state      <= DONE;
                    end else if (w_timeout) begin
                        r_data_fetch <= ERR_DATA;
                        r_bus_err    <= 1'b1;
                        if (r_err_count != 8'hFF) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // The core still holds the finished request here; ignore it.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the core freezes in the accepting cycle.
    assign stall = w_busy || (rst_n && (r_state == IDLE) && data_enable);

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign data_fetch = r_data_fetch;
    assign bus_err    = r_bus_err;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_rv32_dmem_bridge.sv
// Self-checking bench for rv32_dmem_bridge with a transaction-level model.
module tb_rv32_dmem_bridge;

    localparam int          TMO  = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_enable = 1'b0;
    logic        data_read = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_store = '0;
    logic [31:0] data_fetch;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        bus_err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    rv32_dmem_bridge #(
        .TIMEOUT  (TMO),
        .ERR_DATA (ERRD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_enable (data_enable),
        .data_read   (data_read),
        .data_addr   (data_addr),
        .data_store  (data_store),
        .data_fetch  (data_fetch),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .bus_err     (bus_err),
        .err_count   (err_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observations from the most recent transaction.
    int          ob_stall;
    int          ob_req;
    int          ob_err;
    bit          ob_k0_stall;
    bit          ob_hung;
    logic [31:0] ob_fetch;
    logic [7:0]  ob_errcnt;
    logic [31:0] ob_addr_q[$];
    logic [31:0] ob_wdata_q[$];
    logic        ob_we_q[$];

    // Reference model state and per-transaction expectations.
    logic [31:0] m_fetch  = '0;
    int          m_errcnt = 0;
    int          e_busy;
    int          e_req;
    bit          e_to;

    // Transaction outcome from the bus rules: completion index vs. the bound.
    function automatic void model_txn(input bit rd, input int g, input int rv,
                                      input logic [31:0] rdata);
        int c;
        if (!rd) c = g;
        else     c = (g == 0 || rv == 0 || rv < g) ? 0 : rv;
        if (c != 0 && c <= TMO) begin
            e_busy = c;
            e_to   = 1'b0;
        end else begin
            e_busy = TMO;
            e_to   = 1'b1;
        end
        e_req = (g != 0 && g < e_busy) ? g : e_busy;
        if (rd) m_fetch = e_to ? ERRD : rdata;
        if (e_to && m_errcnt < 255) m_errcnt++;
    endfunction

    // Drive one transaction; ends in the first non-stalled cycle (DONE).
    task automatic run_txn(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                           input int gnt_at, input int rv_at, input logic [31:0] rdata);
        bit done = 1'b0;
        ob_stall = 0; ob_req = 0; ob_err = 0; ob_hung = 1'b0;
        ob_addr_q.delete(); ob_wdata_q.delete(); ob_we_q.delete();
        @(negedge clk);
        data_enable = 1'b1; data_read = rd; data_addr = addr; data_store = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        #1;
        ob_k0_stall = stall;
        if (stall) ob_stall++;
        if (bus_err) ob_err++;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            data_addr  = $urandom;
            data_store = $urandom;
            mem_gnt    = (k == gnt_at);
            mem_rvalid = (k == rv_at);
            mem_rdata  = (k == rv_at) ? rdata : $urandom;
            #1;
            if (bus_err) ob_err++;
            if (mem_req) begin
                ob_req++;
                ob_addr_q.push_back(mem_addr);
                ob_wdata_q.push_back(mem_wdata);
                ob_we_q.push_back(mem_we);
            end
            if (!stall) begin
                ob_fetch  = data_fetch;
                ob_errcnt = err_count;
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hFFFF_FFFF;
                done = 1'b1;
                break;
            end
            ob_stall++;
        end
        if (!done) ob_hung = 1'b1;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        data_enable = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'(($urandom_range(0, 1)));
        mem_rdata   = $urandom;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data_enable = 1'b1; data_read = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b exp=0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); else n_pass++;
        n_checks++; if (data_fetch !== 32'h0) $display("FAIL reset_fetch got=%h exp=0", data_fetch); else n_pass++;
        n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err got=%b exp=0", bus_err); else n_pass++;
        n_checks++; if (err_count !== 8'h0) $display("FAIL reset_err_count got=%0d exp=0", err_count); else n_pass++;
        @(negedge clk);
        data_enable = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_fast_load();
        run_txn(1'b1, 32'h0000_0104, 32'h0, 1, 1, 32'h1234_5678);
        model_txn(1'b1, 1, 1, 32'h1234_5678);
        n_checks++; if (ob_stall !== 2) $display("FAIL fast_load_stall got=%0d exp=2", ob_stall); else n_pass++;
        n_checks++; if (ob_req !== 1) $display("FAIL fast_load_req got=%0d exp=1", ob_req); else n_pass++;
        n_checks++; if (ob_fetch !== 32'h1234_5678) $display("FAIL fast_load_fetch got=%h exp=12345678", ob_fetch); else n_pass++;
        n_checks++; if (ob_addr_q.size() == 0 || ob_addr_q[0] !== 32'h0000_0104)
            $display("FAIL fast_load_addr got=%h exp=00000104", ob_addr_q.size() ? ob_addr_q[0] : 32'hx); else n_pass++;
        n_checks++; if (ob_err !== 0) $display("FAIL fast_load_bus_err got=%0d exp=0", ob_err); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_idle();
            n_checks++; if (data_fetch !== 32'h1234_5678) $display("FAIL fast_load_hold%0d got=%h exp=12345678", i, data_fetch); else n_pass++;
            n_checks++; if (stall !== 1'b0) $display("FAIL fast_load_idle_stall%0d got=%b exp=0", i, stall); else n_pass++;
        end
    endtask

    task automatic test_slow_store();
        run_txn(1'b0, 32'h0000_0203, 32'hCAFE_F00D, 4, 2, 32'h5555_5555);
        model_txn(1'b0, 4, 2, 32'h5555_5555);
        n_checks++; if (ob_stall !== 5) $display("FAIL slow_store_stall got=%0d exp=5", ob_stall); else n_pass++;
        n_checks++; if (ob_req !== 4) $display("FAIL slow_store_req got=%0d exp=4", ob_req); else n_pass++;
        for (int i = 0; i < ob_addr_q.size(); i++) begin
            n_checks++; if (ob_addr_q[i] !== 32'h0000_0200) $display("FAIL slow_store_addr%0d got=%h exp=00000200", i, ob_addr_q[i]); else n_pass++;
            n_checks++; if (ob_we_q[i] !== 1'b1) $display("FAIL slow_store_we%0d got=%b exp=1", i, ob_we_q[i]); else n_pass++;
            n_checks++; if (ob_wdata_q[i] !== 32'hCAFE_F00D) $display("FAIL slow_store_wdata%0d got=%h exp=cafef00d", i, ob_wdata_q[i]); else n_pass++;
        end
        n_checks++; if (ob_fetch !== 32'h1234_5678) $display("FAIL slow_store_fetch got=%h exp=12345678", ob_fetch); else n_pass++;
        n_checks++; if (ob_err !== 0) $display("FAIL slow_store_bus_err got=%0d exp=0", ob_err); else n_pass++;
    endtask

    task automatic test_split_load();
        run_txn(1'b1, 32'h0000_0300, 32'h0, 1, 4, 32'hA5A5_A5A5);
        model_txn(1'b1, 1, 4, 32'hA5A5_A5A5);
        n_checks++; if (ob_req !== 1) $display("FAIL split_load_req got=%0d exp=1", ob_req); else n_pass++;
        n_checks++; if (ob_stall !== 5) $display("FAIL split_load_stall got=%0d exp=5", ob_stall); else n_pass++;
        n_checks++; if (ob_fetch !== 32'hA5A5_A5A5) $display("FAIL split_load_fetch got=%h exp=a5a5a5a5", ob_fetch); else n_pass++;
        n_checks++; if (ob_err !== 0) $display("FAIL split_load_bus_err got=%0d exp=0", ob_err); else n_pass++;
        // A request held straight after DONE must be accepted: DONE lasts one cycle.
        run_txn(1'b1, 32'h0000_0304, 32'h0, 1, 1, 32'h0BAD_CAFE);
        model_txn(1'b1, 1, 1, 32'h0BAD_CAFE);
        n_checks++; if (ob_k0_stall !== 1'b1) $display("FAIL split_load_one_done got=%b exp=1", ob_k0_stall); else n_pass++;
        n_checks++; if (ob_fetch !== m_fetch) $display("FAIL split_load_next got=%h exp=%h", ob_fetch, m_fetch); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit          rd[3] = '{1'b0, 1'b1, 1'b0};
        int          g[3]  = '{2, 1, 1};
        int          rv[3] = '{0, 3, 1};
        logic [31:0] d[3]  = '{32'h1111_1111, 32'h7777_0001, 32'h2222_2222};
        for (int i = 0; i < 3; i++) begin
            run_txn(rd[i], 32'h0000_1000 + 32'(i * 4), d[i], g[i], rv[i], d[i]);
            model_txn(rd[i], g[i], rv[i], d[i]);
            n_checks++; if (ob_k0_stall !== 1'b1) $display("FAIL b2b_accept%0d got=%b exp=1", i, ob_k0_stall); else n_pass++;
            n_checks++; if (ob_stall !== 1 + e_busy) $display("FAIL b2b_stall%0d got=%0d exp=%0d", i, ob_stall, 1 + e_busy); else n_pass++;
            n_checks++; if (ob_fetch !== m_fetch) $display("FAIL b2b_fetch%0d got=%h exp=%h", i, ob_fetch, m_fetch); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 32'h0000_0400, 32'h0, 0, 0, 32'h0);
        model_txn(1'b1, 0, 0, 32'h0);
        n_checks++; if (ob_req !== TMO) $display("FAIL timeout_req got=%0d exp=%0d", ob_req, TMO); else n_pass++;
        n_checks++; if (ob_stall !== TMO + 1) $display("FAIL timeout_stall got=%0d exp=%0d", ob_stall, TMO + 1); else n_pass++;
        n_checks++; if (ob_fetch !== 32'hDEAD_BEEF) $display("FAIL timeout_fetch got=%h exp=deadbeef", ob_fetch); else n_pass++;
        n_checks++; if (ob_err !== 1) $display("FAIL timeout_bus_err got=%0d exp=1", ob_err); else n_pass++;
        n_checks++; if (ob_errcnt !== 8'd1) $display("FAIL timeout_err_count got=%0d exp=1", ob_errcnt); else n_pass++;
        drive_idle();
        n_checks++; if (bus_err !== 1'b0) $display("FAIL timeout_pulse_width got=%b exp=0", bus_err); else n_pass++;
        for (int i = 0; i < 300; i++) begin
            run_txn(1'b0, $urandom, $urandom, 0, 0, 32'h0);
            model_txn(1'b0, 0, 0, 32'h0);
            n_checks++; if (ob_errcnt !== 8'(m_errcnt)) $display("FAIL timeout_sat%0d got=%0d exp=%0d", i, ob_errcnt, m_errcnt); else n_pass++;
            n_checks++; if (ob_err !== 1) $display("FAIL timeout_pulse%0d got=%0d exp=1", i, ob_err); else n_pass++;
        end
        drive_idle();
        n_checks++; if (err_count !== 8'd255) $display("FAIL timeout_saturated got=%0d exp=255", err_count); else n_pass++;
        n_checks++; if (data_fetch !== 32'hDEAD_BEEF) $display("FAIL timeout_store_hold got=%h exp=deadbeef", data_fetch); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        data_enable = 1'b1; data_read = 1'b1; data_addr = 32'h0000_0040;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || stall !== 1'b1) $display("FAIL rstmid_wait got=req%b/stall%b exp=req0/stall1", mem_req, stall); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rstmid_req got=%b exp=0", mem_req); else n_pass++;
        n_checks++; if (data_fetch !== 32'h0) $display("FAIL rstmid_fetch got=%h exp=0", data_fetch); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL rstmid_stall got=%b exp=0", stall); else n_pass++;
        n_checks++; if (err_count !== 8'h0) $display("FAIL rstmid_err_count got=%0d exp=0", err_count); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; data_enable = 1'b0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        n_checks++; if (data_fetch !== 32'h0) $display("FAIL rstmid_late_data got=%h exp=0", data_fetch); else n_pass++;
        n_checks++; if (mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rstmid_idle got=req%b/stall%b exp=0/0", mem_req, stall); else n_pass++;
        m_fetch = '0; m_errcnt = 0;
        run_txn(1'b1, 32'h0000_0044, 32'h0, 2, 3, 32'h3C3C_0F0F);
        model_txn(1'b1, 2, 3, 32'h3C3C_0F0F);
        n_checks++; if (ob_fetch !== 32'h3C3C_0F0F) $display("FAIL rstmid_next_fetch got=%h exp=3c3c0f0f", ob_fetch); else n_pass++;
        n_checks++; if (ob_stall !== 4) $display("FAIL rstmid_next_stall got=%0d exp=4", ob_stall); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit          rd = 1'(($urandom_range(0, 1)));
            int          g  = $urandom_range(0, TMO + 2);
            int          rv;
            logic [31:0] a  = $urandom;
            logic [31:0] d  = $urandom;
            if (rd) begin
                rv = (g == 0 || $urandom_range(0, 5) == 0) ? 0 : g + $urandom_range(0, 3);
                if (g == TMO) rv = g;
            end else begin
                rv = $urandom_range(0, TMO);
            end
            run_txn(rd, a, d, g, rv, d);
            model_txn(rd, g, rv, d);
            n_checks++; if (ob_hung !== 1'b0) $display("FAIL rand%0d_hung got=%b exp=0", i, ob_hung); else n_pass++;
            n_checks++; if (ob_stall !== 1 + e_busy) $display("FAIL rand%0d_stall got=%0d exp=%0d", i, ob_stall, 1 + e_busy); else n_pass++;
            n_checks++; if (ob_req !== e_req) $display("FAIL rand%0d_req got=%0d exp=%0d", i, ob_req, e_req); else n_pass++;
            n_checks++; if (ob_fetch !== m_fetch) $display("FAIL rand%0d_fetch got=%h exp=%h", i, ob_fetch, m_fetch); else n_pass++;
            n_checks++; if (ob_err !== int'(e_to)) $display("FAIL rand%0d_bus_err got=%0d exp=%0d", i, ob_err, e_to); else n_pass++;
            n_checks++; if (ob_errcnt !== 8'(m_errcnt)) $display("FAIL rand%0d_err_count got=%0d exp=%0d", i, ob_errcnt, m_errcnt); else n_pass++;
            for (int j = 0; j < ob_addr_q.size(); j++) begin
                n_checks++;
                if (ob_addr_q[j] !== (a & 32'hFFFF_FFFC) || ob_we_q[j] !== !rd || ob_wdata_q[j] !== d)
                    $display("FAIL rand%0d_bus%0d got=%h/%b/%h exp=%h/%b/%h", i, j,
                             ob_addr_q[j], ob_we_q[j], ob_wdata_q[j], a & 32'hFFFF_FFFC, !rd, d);
                else n_pass++;
            end
            if ($urandom_range(0, 2) == 0) drive_idle();
        end
    endtask

    initial begin
        test_reset();
        test_fast_load();
        test_slow_store();
        test_split_load();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
